// File: rtl/ext_arbiter_pkg.sv
// ext_arbiter_pkg: shared definitions for the immediate-extension arbiter.
//   ext_mode_e  : requester mode field encodings (sign / zero / upper / reserved)
//   arb_state_e : result-register state (IDLE = empty, HOLD = result valid)
package ext_arbiter_pkg;

  typedef enum logic [1:0] {
    EXT_MODE_SIGN  = 2'b00,
    EXT_MODE_ZERO  = 2'b01,
    EXT_MODE_UPPER = 2'b10,
    EXT_MODE_RSVD  = 2'b11
  } ext_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ext_core.sv
// ext_core: combinational immediate extension.
//   i_data [NB_IN]  raw immediate
//   i_mode [2]      00 sign-extend, 01 zero-extend, 10 place in upper bits,
//                   11 reserved (result all zero)
//   o_ext  [NB_OUT] extended value; NB_OUT == NB_IN passes i_data through
module ext_core
  import ext_arbiter_pkg::*;
#(
  parameter int unsigned NB_IN  = 16,
  parameter int unsigned NB_OUT = 32
) (
  input  logic [NB_IN-1:0]  i_data,
  input  logic [1:0]        i_mode,
  output logic [NB_OUT-1:0] o_ext
);

  if (NB_OUT < NB_IN) begin : g_bad_width
    $error("ext_core: NB_OUT must be >= NB_IN");
  end else if (NB_OUT == NB_IN) begin : g_pass
    assign o_ext = i_data;
  end else begin : g_ext
    localparam int unsigned PAD = NB_OUT - NB_IN;

    always_comb begin
      o_ext = '0;
      case (ext_mode_e'(i_mode))
        EXT_MODE_SIGN:  o_ext = {{PAD{i_data[NB_IN-1]}}, i_data};
        EXT_MODE_ZERO:  o_ext = {{PAD{1'b0}}, i_data};
        EXT_MODE_UPPER: o_ext = {i_data, {PAD{1'b0}}};
        default:        o_ext = '0;
      endcase
    end
  end

endmodule

// File: rtl/ext_arbiter.sv
// ext_arbiter: two requesters share one ext_core; result is registered with
// valid/ready backpressure (one result per cycle when the consumer is ready).
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_req0/i_data0/i_mode0     requester 0 (decode immediate)
//   i_req1/i_data1/i_mode1     requester 1 (branch offset / debug)
//   o_gnt0, o_gnt1             combinational grant, request taken at this edge
//   o_valid, i_ready           result handshake
//   o_result, o_id             extended value and owning requester
// Build option: EXT_ARB_FIXED_PRIO_EN -> port 0 always wins ties (no rr pointer);
// otherwise ties go to the port not granted last.
module ext_arbiter
  import ext_arbiter_pkg::*;
#(
  parameter int unsigned NB_IN  = 16,
  parameter int unsigned NB_OUT = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic [NB_IN-1:0]  i_data0,
  input  logic [1:0]        i_mode0,
  input  logic              i_req1,
  input  logic [NB_IN-1:0]  i_data1,
  input  logic [1:0]        i_mode1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [NB_OUT-1:0] o_result,
  output logic              o_id
);

  arb_state_e        state_q, state_d;
  logic [NB_OUT-1:0] result_q, result_d;
  logic              id_q, id_d;
  logic              accept;
  logic              gnt0, gnt1;
  logic              prio1;       // 1: port 1 wins a tie this cycle
  logic [NB_IN-1:0]  sel_data;
  logic [1:0]        sel_mode;
  logic [NB_OUT-1:0] ext_val;

`ifdef EXT_ARB_FIXED_PRIO_EN
  assign prio1 = 1'b0;
`else
  logic rr_q, rr_d;

  // Pointer names the port that wins the next tie: the one not granted last.
  always_comb begin
    rr_d = rr_q;
    if (gnt0) rr_d = 1'b1;
    else if (gnt1) rr_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) rr_q <= 1'b0;
    else         rr_q <= rr_d;
  end

  assign prio1 = rr_q;
`endif

  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    accept = (state_q == ST_IDLE) || i_ready;
    if (!i_reset && accept) begin
      if (i_req0 && (!i_req1 || !prio1)) gnt0 = 1'b1;
      else if (i_req1)                   gnt1 = 1'b1;
    end
  end

  assign sel_data = gnt1 ? i_data1 : i_data0;
  assign sel_mode = gnt1 ? i_mode1 : i_mode0;

  ext_core #(
    .NB_IN  (NB_IN),
    .NB_OUT (NB_OUT)
  ) u_ext_core (
    .i_data (sel_data),
    .i_mode (sel_mode),
    .o_ext  (ext_val)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    id_d     = id_q;
    if (gnt0 || gnt1) begin
      state_d  = ST_HOLD;
      result_d = ext_val;
      id_d     = gnt1;
    end else if (state_q == ST_HOLD && i_ready) begin
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      id_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      id_q     <= id_d;
    end
  end

  assign o_gnt0   = gnt0;
  assign o_gnt1   = gnt1;
  assign o_valid  = (state_q == ST_HOLD);
  assign o_result = result_q;
  assign o_id     = id_q;

endmodule

// File: tb/tb_ext_arbiter.sv
module tb_ext_arbiter;

  localparam int NB_IN  = 16;
  localparam int NB_OUT = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [NB_IN-1:0]  data0 = '0, data1 = '0;
  logic [1:0]        mode0 = '0, mode1 = '0;
  logic              ready = 1'b0;
  logic              gnt0, gnt1, valid, id;
  logic [NB_OUT-1:0] result;

  always #5 clk = ~clk;

  ext_arbiter #(
    .NB_IN  (NB_IN),
    .NB_OUT (NB_OUT)
  ) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_req0   (req0),
    .i_data0  (data0),
    .i_mode0  (mode0),
    .i_req1   (req1),
    .i_data1  (data1),
    .i_mode1  (mode1),
    .o_gnt0   (gnt0),
    .o_gnt1   (gnt1),
    .o_valid  (valid),
    .i_ready  (ready),
    .o_result (result),
    .o_id     (id)
  );

  int checks   = 0;
  int failures = 0;

  // Transaction-level reference: what the consumer should see.
  bit          m_valid  = 0;
  logic [31:0] m_result = '0;
  int          m_id     = 0;
  int          last_gnt = 1;   // port granted most recently; 1 => port 0 wins first tie

  function automatic logic [31:0] ref_ext(logic [15:0] d, logic [1:0] m);
    int s;
    case (m)
      2'd0: begin s = $signed(d); return s; end
      2'd1: return 32'(d);
      2'd2: return 32'(d) * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check grants before posedge, check outputs after.
  task automatic step(input bit rst, input bit r0, input logic [15:0] d0, input logic [1:0] md0,
                      input bit r1, input logic [15:0] d1, input logic [1:0] md1,
                      input bit rdy, input string tag, output int won);
    int w;
    @(negedge clk);
    reset = rst; req0 = r0; data0 = d0; mode0 = md0;
    req1 = r1; data1 = d1; mode1 = md1; ready = rdy;
    #1;
    w = -1;
    if (!rst && (!m_valid || rdy)) begin
      if (r0 && r1) begin
`ifdef EXT_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = (last_gnt == 0) ? 1 : 0;
`endif
      end else if (r0) w = 0;
      else if (r1)     w = 1;
    end
    chk({tag, ".gnt0"}, 32'(gnt0), 32'(w == 0));
    chk({tag, ".gnt1"}, 32'(gnt1), 32'(w == 1));
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_result = '0; m_id = 0; last_gnt = 1;
    end else if (w >= 0) begin
      m_valid  = 1;
      m_result = (w == 1) ? ref_ext(d1, md1) : ref_ext(d0, md0);
      m_id     = w;
      last_gnt = w;
    end else if (rdy) begin
      m_valid = 0;
    end
    chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
    if (m_valid || rst) begin
      chk({tag, ".result"}, result, m_result);
      chk({tag, ".id"}, 32'(id), 32'(m_id));
    end
    won = w;
  endtask

  initial begin
    int w;
    bit p0, p1, rs;
    logic [15:0] rd0, rd1;
    logic [1:0]  rm0, rm1;

    step(1, 0, '0, 0, 0, '0, 0, 0, "rst", w);
    step(1, 0, '0, 0, 0, '0, 0, 1, "rst", w);
    chk("rst.valid_const", 32'(valid), 32'd0);
    chk("rst.result_const", result, 32'd0);

    // 1: sign extension on port 0
    step(0, 1, 16'h8001, 2'b00, 0, '0, 0, 1, "t1", w);
    chk("t1.result_const", result, 32'hFFFF8001);
    step(0, 0, '0, 0, 0, '0, 0, 1, "t1.drain", w);

    // 2: port 1 zero then upper, back-to-back
    step(0, 0, '0, 0, 1, 16'h8001, 2'b01, 1, "t2a", w);
    chk("t2a.result_const", result, 32'h00008001);
    step(0, 0, '0, 0, 1, 16'h8001, 2'b10, 1, "t2b", w);
    chk("t2b.result_const", result, 32'h80010000);
    chk("t2b.id_const", 32'(id), 32'd1);
    step(0, 0, '0, 0, 0, '0, 0, 1, "t2.drain", w);

    // 3: both requesting continuously after reset
    step(1, 0, '0, 0, 0, '0, 0, 1, "t3.rst", w);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 16'(i), 2'b01, 1, 16'(100 + i), 2'b01, 1, "t3", w);
`ifdef EXT_ARB_FIXED_PRIO_EN
      chk("t3.order", 32'(w), 32'd0);
`else
      chk("t3.order", 32'(w), 32'(i % 2));
`endif
    end
    step(0, 0, '0, 0, 0, '0, 0, 1, "t3.drain", w);

    // 4: backpressure holds result and blocks grants
    step(0, 1, 16'h1234, 2'b00, 0, '0, 0, 1, "t4.load", w);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 16'hBEEF, 2'b01, 0, '0, 0, 0, "t4.stall", w);
      chk("t4.stable", result, 32'h00001234);
    end
    step(0, 1, 16'hBEEF, 2'b01, 0, '0, 0, 1, "t4.go", w);
    chk("t4.new", result, 32'h0000BEEF);

    // 5: reserved mode
    step(0, 1, 16'hFFFF, 2'b11, 0, '0, 0, 1, "t5", w);
    chk("t5.result_const", result, 32'd0);
    chk("t5.valid_const", 32'(valid), 32'd1);

    // 6: reset while holding; pointer returns to port 0
    step(0, 1, 16'h7777, 2'b01, 0, '0, 0, 0, "t6.load", w);
    step(0, 0, '0, 0, 0, '0, 0, 0, "t6.hold", w);
    step(1, 0, '0, 0, 0, '0, 0, 0, "t6.rst", w);
    chk("t6.result_const", result, 32'd0);
    step(0, 1, 16'h0001, 2'b01, 1, 16'h0002, 2'b01, 1, "t6.tie", w);
    chk("t6.tie_const", 32'(w), 32'd0);
    step(0, 0, '0, 0, 0, '0, 0, 1, "t6.drain", w);

    // Random traffic honouring the hold-until-granted request rule.
    p0 = 0; p1 = 0; rd0 = '0; rd1 = '0; rm0 = '0; rm1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && ($urandom_range(0, 2) == 0)) begin
        p0 = 1; rd0 = 16'($urandom); rm0 = 2'($urandom);
      end
      if (!p1 && ($urandom_range(0, 2) == 0)) begin
        p1 = 1; rd1 = 16'($urandom); rm1 = 2'($urandom);
      end
      rs = ($urandom_range(0, 59) == 0);
      step(rs, p0, rd0, rm0, p1, rd1, rm1, 1'($urandom_range(0, 3) != 0), "rnd", w);
      if (w == 0) p0 = 0;
      if (w == 1) p1 = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
